interrupt_controller: RTL and testbench

Multi-source interrupt front end that sits ahead of the decode-stage interrupt handler and schedules it. Rising edges on NUM_IRQ external request lines are latched as pending, filtered by a mask, and arbitrated. The controller then drives the handler's single interruptBit, tracks the handler's sequencing and the ISR body through RTI, and only then grants the next source. It shares the one interrupt-injection path among several requesters and guarantees no nesting.

---
 rtl/interrupt_controller_if.sv | 28 ++
 rtl/interrupt_controller.sv | 145 ++++++++++++++
 tb/tb_interrupt_controller.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/interrupt_controller_if.sv
// Bundle of request, handler-sequencing and grant signals between the
// interrupt controller and its environment. The controller uses the slave
// modport; whatever drives the request lines and models the handler uses
// the master modport.
interface interrupt_controller_if #(
  parameter int NUM_IRQ = 4
);
  localparam int VW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  logic [NUM_IRQ-1:0] irqIn;
  logic [NUM_IRQ-1:0] irqMask;
  logic               handlerActive;
  logic               rtiDone;
  logic               interruptBit;
  logic [VW-1:0]      irqVector;
  logic [NUM_IRQ-1:0] irqAck;
  logic               inService;

  modport slave (
    input  irqIn, irqMask, handlerActive, rtiDone,
    output interruptBit, irqVector, irqAck, inService
  );

  modport master (
    output irqIn, irqMask, handlerActive, rtiDone,
    input  interruptBit, irqVector, irqAck, inService
  );
endinterface

// File: rtl/interrupt_controller.sv
// Multi-source interrupt front end. Rising edges on the request lines are
// latched as pending, masked, arbitrated, and the winner is handed to the
// decode-stage handler through a single interruptBit pulse. The controller
// follows the handler and the ISR body through RTI before granting again,
// so interrupts never nest.
//
// Optional feature: define IRQ_ROUND_ROBIN_EN for round-robin arbitration
// (search starts after the last granted source). Without it, the lowest
// eligible index wins and no pointer state exists.
//
// state        | meaning
// -------------+--------------------------------------------------------
// IDLE         | nothing in service; grant the arbitration winner
// RAISE        | first interruptBit pulse, ack the granted pending bit
// WAIT_ACCEPT  | wait for handlerActive; timer counts down to a retry
// RETRY        | interruptBit low one cycle so the re-raise is a new edge
// RERAISE      | repeat interruptBit pulse, no ack, timer reloaded
// IN_HANDLER   | handler injecting its bubble/INT sequence
// IN_ISR       | ISR body running; wait for rtiDone
module interrupt_controller #(
  parameter int NUM_IRQ        = 4,
  parameter int ACCEPT_TIMEOUT = 8
) (
  input logic                    clk,
  input logic                    rstN,
  interrupt_controller_if.slave  bus
);
  localparam int VW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RAISE,
    S_WAIT_ACCEPT,
    S_RETRY,
    S_RERAISE,
    S_IN_HANDLER,
    S_IN_ISR
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [NUM_IRQ-1:0] irq_prev;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] ack;
  logic               any_eligible;
  logic [VW-1:0]      vec;
  logic [VW-1:0]      winner;
  logic [7:0]         timer;

  assign rise         = bus.irqIn & ~irq_prev;
  assign eligible     = pending & bus.irqMask;
  assign any_eligible = |eligible;
  assign ack          = (state == S_RAISE) ? (NUM_IRQ'(1) << vec) : '0;

  assign bus.interruptBit = (state == S_RAISE) || (state == S_RERAISE);
  assign bus.irqAck       = ack;
  assign bus.irqVector    = vec;
  assign bus.inService    = (state != S_IDLE);

`ifdef IRQ_ROUND_ROBIN_EN
  logic [VW-1:0] last_grant;

  // Round-robin search starting one past the last granted source, wrapping at NUM_IRQ.
  always_comb begin
    logic [VW:0] slot;
    logic        found;
    winner = '0;
    found  = 1'b0;
    slot   = '0;
    for (int k = 1; k <= NUM_IRQ; k++) begin
      slot = {1'b0, last_grant} + (VW+1)'(k);
      if (slot >= (VW+1)'(NUM_IRQ)) slot = slot - (VW+1)'(NUM_IRQ);
      if (!found && eligible[VW'(slot)]) begin
        winner = VW'(slot);
        found  = 1'b1;
      end
    end
  end

  // Pointer advances only when a new grant leaves IDLE.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      last_grant <= '0;
    end else if (state == S_IDLE && any_eligible) begin
      last_grant <= winner;
    end
  end
`else
  // Fixed priority: scanning downward leaves the lowest eligible index as winner.
  always_comb begin
    winner = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) winner = VW'(i);
    end
  end
`endif

  // Edge detection and pending bits; a new edge in the ack cycle keeps the bit set.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      irq_prev <= '0;
      pending  <= '0;
    end else begin
      irq_prev <= bus.irqIn;
      pending  <= (pending & ~ack) | rise;
    end
  end

  // State register, granted vector and accept timeout down-counter.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= S_IDLE;
      vec   <= '0;
      timer <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && any_eligible) vec <= winner;
      if (state == S_RAISE || state == S_RERAISE) begin
        timer <= 8'(ACCEPT_TIMEOUT);
      end else if (state == S_WAIT_ACCEPT && timer != 8'd0) begin
        timer <= timer - 8'd1;
      end
    end
  end

  // Next-state logic; handler acceptance takes priority over the timeout.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:        if (any_eligible) state_nxt = S_RAISE;
      S_RAISE:       state_nxt = S_WAIT_ACCEPT;
      S_WAIT_ACCEPT: begin
        if (bus.handlerActive)    state_nxt = S_IN_HANDLER;
        else if (timer <= 8'd1)   state_nxt = S_RETRY;
      end
      S_RETRY:       state_nxt = S_RERAISE;
      S_RERAISE:     state_nxt = S_WAIT_ACCEPT;
      S_IN_HANDLER:  if (!bus.handlerActive) state_nxt = S_IN_ISR;
      S_IN_ISR:      if (bus.rtiDone) state_nxt = S_IDLE;
      default:       state_nxt = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller in its default (fixed priority)
// build. Inputs change and outputs are sampled 1 time unit after the rising
// clock edge.
module tb_interrupt_controller;
  logic clk = 1'b0;
  logic rstN;
  int   checks   = 0;
  int   failures = 0;

  interrupt_controller_if #(.NUM_IRQ(4)) bus ();

  interrupt_controller #(.NUM_IRQ(4), .ACCEPT_TIMEOUT(8)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Handler accepts right after a RAISE sample: high two cycles, then RTI.
  task automatic run_handler();
    bus.handlerActive = 1'b1;
    step();
    step();
    bus.handlerActive = 1'b0;
    step();
    bus.rtiDone = 1'b1;
    step();
    bus.rtiDone = 1'b0;
  endtask

  initial begin
    rstN              = 1'b0;
    bus.irqIn         = '0;
    bus.irqMask       = 4'b1111;
    bus.handlerActive = 1'b0;
    bus.rtiDone       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ib",   32'(bus.interruptBit), 32'd0);
    chk("rst_ack",  32'(bus.irqAck),       32'd0);
    chk("rst_vec",  32'(bus.irqVector),    32'd0);
    chk("rst_insv", 32'(bus.inService),    32'd0);
    rstN = 1'b1;
    step();
    step();
    chk("idle_ib", 32'(bus.interruptBit), 32'd0);

    // single request on line 2
    bus.irqIn = 4'b0100;
    step();
    bus.irqIn = 4'b0000;
    chk("single_pend_ib", 32'(bus.interruptBit), 32'd0);
    step();
    chk("single_ib",   32'(bus.interruptBit), 32'd1);
    chk("single_vec",  32'(bus.irqVector),    32'd2);
    chk("single_ack",  32'(bus.irqAck),       32'b0100);
    chk("single_insv", 32'(bus.inService),    32'd1);
    bus.handlerActive = 1'b1;
    step();
    chk("single_wait_ib",  32'(bus.interruptBit), 32'd0);
    chk("single_wait_ack", 32'(bus.irqAck),       32'd0);
    step();
    bus.handlerActive = 1'b0;
    step();
    chk("single_isr_insv", 32'(bus.inService), 32'd1);
    chk("single_isr_vec",  32'(bus.irqVector), 32'd2);
    bus.rtiDone = 1'b1;
    step();
    bus.rtiDone = 1'b0;
    chk("single_done_insv", 32'(bus.inService),    32'd0);
    chk("single_done_ib",   32'(bus.interruptBit), 32'd0);
    step();
    step();
    chk("single_no_rerun", 32'(bus.interruptBit), 32'd0);

    // simultaneous edges on 3 and 1: fixed priority grants 1 then 3
    bus.irqIn = 4'b1010;
    step();
    bus.irqIn = 4'b0000;
    step();
    chk("pair_first_vec", 32'(bus.irqVector), 32'd1);
    chk("pair_first_ack", 32'(bus.irqAck),    32'b0010);
    run_handler();
    chk("pair_gap_ib",   32'(bus.interruptBit), 32'd0);
    chk("pair_gap_insv", 32'(bus.inService),    32'd0);
    step();
    chk("pair_second_ib",  32'(bus.interruptBit), 32'd1);
    chk("pair_second_vec", 32'(bus.irqVector),    32'd3);
    chk("pair_second_ack", 32'(bus.irqAck),       32'b1000);
    run_handler();
    step();
    chk("pair_drained", 32'(bus.inService), 32'd0);

    // masked request stays pending until unmasked
    bus.irqMask = 4'b1110;
    bus.irqIn   = 4'b0001;
    step();
    bus.irqIn = 4'b0000;
    step();
    step();
    chk("mask_no_ib",   32'(bus.interruptBit), 32'd0);
    chk("mask_no_insv", 32'(bus.inService),    32'd0);
    bus.irqMask = 4'b1111;
    step();
    chk("unmask_ib",  32'(bus.interruptBit), 32'd1);
    chk("unmask_vec", 32'(bus.irqVector),    32'd0);
    chk("unmask_ack", 32'(bus.irqAck),       32'b0001);

    // request on 1 arrives while source 0 is in its ISR
    bus.handlerActive = 1'b1;
    step();
    step();
    bus.handlerActive = 1'b0;
    step();
    bus.irqIn = 4'b0010;
    step();
    bus.irqIn = 4'b0000;
    step();
    step();
    chk("svc_hold_ib",   32'(bus.interruptBit), 32'd0);
    chk("svc_hold_insv", 32'(bus.inService),    32'd1);
    chk("svc_hold_vec",  32'(bus.irqVector),    32'd0);
    bus.rtiDone = 1'b1;
    step();
    bus.rtiDone = 1'b0;
    chk("svc_idle_ib",   32'(bus.interruptBit), 32'd0);
    chk("svc_idle_insv", 32'(bus.inService),    32'd0);
    step();
    chk("svc_next_ib",  32'(bus.interruptBit), 32'd1);
    chk("svc_next_vec", 32'(bus.irqVector),    32'd1);
    chk("svc_next_ack", 32'(bus.irqAck),       32'b0010);
    run_handler();

    // accept timeout: 9 low cycles then a re-raise without ack; stray rtiDone ignored
    bus.irqIn = 4'b0100;
    step();
    bus.irqIn = 4'b0000;
    step();
    chk("to_raise_ib",  32'(bus.interruptBit), 32'd1);
    chk("to_raise_ack", 32'(bus.irqAck),       32'b0100);
    for (int n = 0; n < 9; n++) begin
      bus.rtiDone = (n == 3);
      step();
      chk("to_low_ib",   32'(bus.interruptBit), 32'd0);
      chk("to_low_ack",  32'(bus.irqAck),       32'd0);
      chk("to_low_insv", 32'(bus.inService),    32'd1);
    end
    bus.rtiDone = 1'b0;
    step();
    chk("to_reraise_ib",  32'(bus.interruptBit), 32'd1);
    chk("to_reraise_ack", 32'(bus.irqAck),       32'd0);
    chk("to_reraise_vec", 32'(bus.irqVector),    32'd2);
    run_handler();
    chk("to_done_insv", 32'(bus.inService), 32'd0);

    // asynchronous reset during IN_HANDLER loses pending requests
    bus.irqIn = 4'b0100;
    step();
    bus.irqIn = 4'b0000;
    step();
    chk("rmid_raise_vec", 32'(bus.irqVector), 32'd2);
    bus.handlerActive = 1'b1;
    step();
    step();
    bus.irqIn = 4'b1000;
    step();
    chk("rmid_inhandler_insv", 32'(bus.inService), 32'd1);
    #2;
    rstN              = 1'b0;
    bus.irqIn         = 4'b0000;
    bus.handlerActive = 1'b0;
    #1;
    chk("rmid_ib",   32'(bus.interruptBit), 32'd0);
    chk("rmid_insv", 32'(bus.inService),    32'd0);
    chk("rmid_vec",  32'(bus.irqVector),    32'd0);
    chk("rmid_ack",  32'(bus.irqAck),       32'd0);
    step();
    rstN = 1'b1;
    for (int n = 0; n < 4; n++) begin
      step();
      chk("rpost_no_ib", 32'(bus.interruptBit), 32'd0);
    end
    bus.irqIn = 4'b1000;
    step();
    bus.irqIn = 4'b0000;
    step();
    chk("rpost_new_ib",  32'(bus.interruptBit), 32'd1);
    chk("rpost_new_vec", 32'(bus.irqVector),    32'd3);
    run_handler();
    chk("rpost_done_insv", 32'(bus.inService), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
